// File: rtl/systolic_feeder_if.sv
// Row-load handshake, feed control and array edge signals of systolic_feeder.
// The feeder uses the slave view; whatever loads operands and watches the feed uses master.
interface systolic_feeder_if #(
  parameter int DATA_BIT = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sel;
  logic [1:0]            in_row;
  logic [4*DATA_BIT-1:0] in_data;
  logic                  start;
  logic                  busy;
  logic                  feed_done;
  logic                  array_clr;
  logic [DATA_BIT-1:0]   west0, west1, west2, west3;
  logic [DATA_BIT-1:0]   north0, north1, north2, north3;

  modport master (
    output in_valid, in_sel, in_row, in_data, start,
    input  in_ready, busy, feed_done, array_clr,
    input  west0, west1, west2, west3, north0, north1, north2, north3
  );

  modport slave (
    input  in_valid, in_sel, in_row, in_data, start,
    output in_ready, busy, feed_done, array_clr,
    output west0, west1, west2, west3, north0, north1, north2, north3
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers 4x4 operands A and B and streams them diagonally skewed into a 4x4
// output-stationary systolic array, clearing the array first.
module systolic_feeder #(
  parameter int DATA_BIT = 8,
  parameter int DRAIN    = 3
) (
  input  logic           clk,
  input  logic           rst,
  systolic_feeder_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN - 1);

  state_t              r_state;
  logic [2:0]          r_step;
  logic [3:0]          r_drain;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_feed_done;
  logic                r_array_clr;
  logic [DATA_BIT-1:0] r_a     [4][4];
  logic [DATA_BIT-1:0] r_b     [4][4];
  logic [DATA_BIT-1:0] r_west  [4];
  logic [DATA_BIT-1:0] r_north [4];

  // Edge values are registered one step ahead: the step about to be shown.
  logic [2:0]          w_next_step;
  logic [DATA_BIT-1:0] w_west  [4];
  logic [DATA_BIT-1:0] w_north [4];

  assign w_next_step = (r_state == S_STREAM) ? r_step + 3'd1 : 3'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_skew
    logic [2:0] w_k;
    logic       w_live;
    assign w_k         = w_next_step - 3'(gi);
    assign w_live      = (w_next_step >= 3'(gi)) && (w_k <= 3'd3);
    assign w_west[gi]  = w_live ? r_a[gi][w_k[1:0]] : '0;
    assign w_north[gi] = w_live ? r_b[w_k[1:0]][gi] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_drain     <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_feed_done <= 1'b0;
      r_array_clr <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
        for (int j = 0; j < 4; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
      end
    end else begin
      r_feed_done <= 1'b0;
      r_array_clr <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            for (int c = 0; c < 4; c++) begin
              if (bus.in_sel) r_b[bus.in_row][c] <= bus.in_data[DATA_BIT*c +: DATA_BIT];
              else            r_a[bus.in_row][c] <= bus.in_data[DATA_BIT*c +: DATA_BIT];
            end
          end
          if (bus.start) begin
            r_state     <= S_CLEAR;
            r_array_clr <= 1'b1;
            r_busy      <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_state <= S_STREAM;
          r_step  <= '0;
          for (int i = 0; i < 4; i++) begin
            r_west[i]  <= w_west[i];
            r_north[i] <= w_north[i];
          end
        end
        S_STREAM: begin
          if (r_step == 3'd6) begin
            r_state <= S_DRAIN;
            r_step  <= '0;
            r_drain <= DRAIN_LOAD;
          end else begin
            r_step <= r_step + 3'd1;
            for (int i = 0; i < 4; i++) begin
              r_west[i]  <= w_west[i];
              r_north[i] <= w_north[i];
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == 4'd0) begin
            r_state     <= S_DONE;
            r_feed_done <= 1'b1;
          end else begin
            r_drain <= r_drain - 4'd1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.feed_done = r_feed_done;
  assign bus.array_clr = r_array_clr;
  assign bus.west0     = r_west[0];
  assign bus.west1     = r_west[1];
  assign bus.west2     = r_west[2];
  assign bus.west3     = r_west[3];
  assign bus.north0    = r_north[0];
  assign bus.north1    = r_north[1];
  assign bus.north2    = r_north[2];
  assign bus.north3    = r_north[3];
endmodule
